clock_gen: RTL and testbench
============================

// Module: clock_gen
// PURPOSE
//  Synthesizable game-tick clock generator; replaces the behavioural free-running clock model.
//  Divides the system clock into a 50%-duty engine clock clk_out with a programmable half-period.
//  Also emits a one-cycle tick pulse on each clk_out rising edge.
//  Sits at the top of the engine and drives the per-tick command/display loop.
// PARAMETERS
//  DIV_W        16  width of half-period value and phase counter
//  DEFAULT_HALF 1   half-period, in clk cycles, loaded at reset
// PORTS
//  clk          in   1      system clock; all logic is rising-edge clocked on it
//  rst          in   1      asynchronous, active-high reset
//  en           in   1      run enable
//  load         in   1      when 1, captures half_period into the shadow register
//  half_period  in   DIV_W  requested half-period in clk cycles; 0 is treated as 1
//  clk_out      out  1      divided engine clock, registered, glitch-free
//  tick         out  1      1-cycle pulse, high in the same cycle clk_out rises
//  phase_cnt    out  DIV_W  current in-phase count, for debug
// BEHAVIOUR
//  - Reset (async, immediate): state=PARK, clk_out=0, tick=0, phase_cnt=0.
//    Shadow and active half-period both = DEFAULT_HALF. Reset mid-high-phase drops clk_out at once.
//  - Registers: shadow_half is written on load; active_half is copied from shadow_half only at a phase toggle.
//  - Value 0 is clamped to 1 when it is written to shadow_half.
//  - FSM states:
//    - PARK: clk_out=0, phase_cnt=0. If en is sampled 1 -> LOW with cnt=0; active_half<=shadow_half.
//    - LOW:  cnt increments each cycle. At the edge where cnt==active_half-1:
//      -> HIGH, clk_out<=1, tick<=1, cnt<=0, active_half<=shadow_half.
//      If en drops while in LOW -> PARK on the next edge (clk_out is already 0, so no glitch).
//    - HIGH: cnt increments each cycle. At the edge where cnt==active_half-1, clk_out<=0, cnt<=0,
//      active_half<=shadow_half; next state is LOW if en=1, else PARK.
//      en low never truncates a HIGH phase.
//  - Each LOW or HIGH phase lasts exactly active_half clk cycles; period = 2*active_half.
//  - Latency: en sampled at edge N from PARK -> first clk_out rise at edge N+half.
//  - tick is high for exactly one clk cycle per rising edge of clk_out, and never in PARK.
//  - load while running: the phase in progress completes with the old value; the new value applies from the next phase.
//  - load and a toggle on the same edge: the toggle copies the old shadow; the new value applies one phase later.
//  - Counter compare is unsigned DIV_W-bit. Max half = 2^DIV_W-1, with no wrap.
// CONFIGURATION
//  CLOCK_GEN_TICK_CNT_EN defined: adds output tick_cnt (32 bits).
//    tick_cnt is reset to 0 and increments on every tick; it wraps 0xFFFFFFFF -> 0.
//  Not defined: no tick_cnt port and no counter logic; all other behaviour is identical.
// STRUCTURE
//  Package clock_gen_pkg holds:
//    - typedef enum {PARK, LOW, HIGH} clkgen_state_t
//    - localparam DIV_W_DEFAULT=16
//    - the clamp function clamp_half(v) = (v==0)?1:v
//  Sub-module clock_gen_div_cnt: phase counter with a terminal-count flag.
//    Inputs: clk, rst, clr, inc, limit. Outputs: cnt, tc.
//  FSM and output registers stay in clock_gen.
// TESTING
//  1. Reset, load half=3, en=1: clk_out is 3 cycles low then 3 cycles high, repeating.
//     tick every 6 cycles; first rise 3 edges after en is sampled.
//  2. Load half=0: clamped to 1; clk_out toggles every clk cycle (period 2); tick every 2 cycles.
//  3. half=4 running, load half=2 in cycle 1 of a HIGH phase:
//     that HIGH lasts 4 cycles, following phases last 2.
//  4. en=0 in cycle 0 of a HIGH phase (half=5): HIGH completes all 5 cycles.
//     clk_out then stays 0, state PARK, no further tick; re-enable gives a rise 5 edges later.
//  5. Assert rst mid-HIGH: clk_out=0 and tick=0 without waiting for a clk edge.
//     After release with en=1, DEFAULT_HALF timing is restored.
//  6. With CLOCK_GEN_TICK_CNT_EN, half=1, en=1 for 20 cycles from PARK: tick_cnt==10.
//     Preloading the counter to 0xFFFFFFFF then wraps it to 0 on the next tick.

Source files
------------

// File: rtl/clock_gen_pkg.sv
// Shared types, defaults and the half-period clamp for the clock_gen block.
package clock_gen_pkg;

  typedef enum logic [1:0] {
    PARK = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } clkgen_state_t;

  localparam int DIV_W_DEFAULT = 16;

  function automatic logic [31:0] clamp_half(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/clock_gen_div_cnt.sv
// Phase counter: clears or increments each clk; tc flags the last cycle of a phase.
module clock_gen_div_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] one = W'(1);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + one;
    end
  end

  // limit is never 0 (clamped upstream), so limit-1 cannot wrap
  assign tc  = (cnt_reg == (limit - one));
  assign cnt = cnt_reg;

endmodule

// File: rtl/clock_gen.sv
// Programmable 50%-duty engine clock divider with a one-cycle tick on each rise.
// Define CLOCK_GEN_TICK_CNT_EN to add the 32-bit tick_cnt output.
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEFAULT,
  parameter int DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] half_period,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] phase_cnt
`ifdef CLOCK_GEN_TICK_CNT_EN
  ,
  output logic [31:0]      tick_cnt
`endif
);

  localparam logic [DIV_W-1:0] reset_half = DIV_W'(clamp_half(32'(DEFAULT_HALF)));

  clkgen_state_t    state_reg, state_next;
  logic [DIV_W-1:0] shadow_reg;
  logic [DIV_W-1:0] active_reg, active_next;
  logic             clk_out_reg, clk_out_next;
  logic             tick_reg, tick_next;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [DIV_W-1:0] cnt;

  clock_gen_div_cnt #(.W(DIV_W)) u_div_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (active_reg),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg <= reset_half;
    end else if (load) begin
      shadow_reg <= DIV_W'(clamp_half(32'(half_period)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= PARK;
      active_reg  <= reset_half;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      active_reg  <= active_next;
      clk_out_reg <= clk_out_next;
      tick_reg    <= tick_next;
    end
  end

  // Any phase change reloads active_reg from the shadow, so loads only take effect at boundaries
  always_comb begin
    state_next   = state_reg;
    active_next  = active_reg;
    clk_out_next = clk_out_reg;
    tick_next    = 1'b0;
    cnt_clr      = 1'b1;
    cnt_inc      = 1'b0;
    case (state_reg)
      PARK: begin
        clk_out_next = 1'b0;
        if (en) begin
          state_next  = LOW;
          active_next = shadow_reg;
        end
      end
      LOW: begin
        if (!en) begin
          state_next = PARK;
        end else if (cnt_tc) begin
          state_next   = HIGH;
          clk_out_next = 1'b1;
          tick_next    = 1'b1;
          active_next  = shadow_reg;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_tc) begin
          state_next   = en ? LOW : PARK;
          clk_out_next = 1'b0;
          active_next  = shadow_reg;
        end else begin
          cnt_clr = 1'b0;
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_next   = PARK;
        clk_out_next = 1'b0;
      end
    endcase
  end

  assign clk_out   = clk_out_reg;
  assign tick      = tick_reg;
  assign phase_cnt = cnt;

`ifdef CLOCK_GEN_TICK_CNT_EN
  logic [31:0] tick_cnt_reg;

  // Counts on the same edge that raises tick, so the value already includes the visible pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= 32'd0;
    end else if (tick_next) begin
      tick_cnt_reg <= tick_cnt_reg + 32'd1;
    end
  end

  assign tick_cnt = tick_cnt_reg;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Directed self-checking bench for clock_gen: vector table plus multi-cycle corner sequences.
module tb_clock_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] half_period;
  logic        clk_out;
  logic        tick;
  logic [15:0] phase_cnt;
`ifdef CLOCK_GEN_TICK_CNT_EN
  logic [31:0] tick_cnt;
`endif

  int passed = 0;
  int total  = 0;

  clock_gen #(.DIV_W(16), .DEFAULT_HALF(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .half_period (half_period),
    .clk_out     (clk_out),
    .tick        (tick),
    .phase_cnt   (phase_cnt)
`ifdef CLOCK_GEN_TICK_CNT_EN
    ,
    .tick_cnt    (tick_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        load;
    logic [15:0] hp;
    logic        exp_clk;
    logic        exp_tick;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic stepchk(input string name, input logic ec, input logic et, input logic [15:0] ecnt);
    step();
    chk({name, ".clk_out"}, 32'(clk_out), 32'(ec));
    chk({name, ".tick"}, 32'(tick), 32'(et));
    chk({name, ".phase_cnt"}, 32'(phase_cnt), 32'(ecnt));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    half_period = 16'd0;
    step();
    step();
    chk("reset.clk_out", 32'(clk_out), 32'd0);
    chk("reset.tick", 32'(tick), 32'd0);
    chk("reset.phase_cnt", 32'(phase_cnt), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    load = 1'b0;
    half_period = 16'd0;

    // Test 1: half=3 from PARK; first rise three edges after en is sampled
    vecs[0]  = '{1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd2};
    vecs[4]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 16'd2};
    vecs[7]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0};
    vecs[8]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd2};
    vecs[10] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 16'd0};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      en = vecs[i].en;
      load = vecs[i].load;
      half_period = vecs[i].hp;
      stepchk($sformatf("t1.v%0d", i), vecs[i].exp_clk, vecs[i].exp_tick, vecs[i].exp_cnt);
      $display("t1 vec %0d: en=%0b load=%0b hp=%0d -> clk_out=%0b tick=%0b phase_cnt=%0d",
               i, vecs[i].en, vecs[i].load, vecs[i].hp, clk_out, tick, phase_cnt);
    end

    // Test 2: half=0 is clamped to 1, so clk_out toggles every cycle
    do_reset();
    load = 1'b1;
    half_period = 16'd0;
    stepchk("t2.park", 1'b0, 1'b0, 16'd0);
    load = 1'b0;
    en = 1'b1;
    stepchk("t2.low0", 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < 6; i++) begin
      stepchk($sformatf("t2.c%0d", i), (i % 2 == 0), (i % 2 == 0), 16'd0);
    end
    $display("t2 done: half=0 clamp sequence");

    // Test 3: load half=2 during cycle 1 of a half=4 HIGH phase
    do_reset();
    load = 1'b1;
    half_period = 16'd4;
    stepchk("t3.park", 1'b0, 1'b0, 16'd0);
    load = 1'b0;
    en = 1'b1;
    stepchk("t3.l0", 1'b0, 1'b0, 16'd0);
    stepchk("t3.l1", 1'b0, 1'b0, 16'd1);
    stepchk("t3.l2", 1'b0, 1'b0, 16'd2);
    stepchk("t3.l3", 1'b0, 1'b0, 16'd3);
    stepchk("t3.h0", 1'b1, 1'b1, 16'd0);
    stepchk("t3.h1", 1'b1, 1'b0, 16'd1);
    load = 1'b1;
    half_period = 16'd2;
    stepchk("t3.h2", 1'b1, 1'b0, 16'd2);
    load = 1'b0;
    stepchk("t3.h3", 1'b1, 1'b0, 16'd3);
    stepchk("t3.n_l0", 1'b0, 1'b0, 16'd0);
    stepchk("t3.n_l1", 1'b0, 1'b0, 16'd1);
    stepchk("t3.n_h0", 1'b1, 1'b1, 16'd0);
    stepchk("t3.n_h1", 1'b1, 1'b0, 16'd1);
    stepchk("t3.n2_l0", 1'b0, 1'b0, 16'd0);
    $display("t3 done: load mid-HIGH sequence");

    // Test 4: en dropped in cycle 0 of a half=5 HIGH phase
    do_reset();
    load = 1'b1;
    half_period = 16'd5;
    stepchk("t4.park", 1'b0, 1'b0, 16'd0);
    load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 5; i++) stepchk($sformatf("t4.l%0d", i), 1'b0, 1'b0, 16'(i));
    stepchk("t4.h0", 1'b1, 1'b1, 16'd0);
    en = 1'b0;
    for (int i = 1; i < 5; i++) stepchk($sformatf("t4.h%0d", i), 1'b1, 1'b0, 16'(i));
    for (int i = 0; i < 6; i++) stepchk($sformatf("t4.park%0d", i), 1'b0, 1'b0, 16'd0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) stepchk($sformatf("t4.r%0d", i), 1'b0, 1'b0, 16'(i));
    stepchk("t4.rise", 1'b1, 1'b1, 16'd0);
    $display("t4 done: en drop in HIGH sequence");

    // Test 5: asynchronous reset while clk_out and tick are high
    do_reset();
    load = 1'b1;
    half_period = 16'd3;
    stepchk("t5.park", 1'b0, 1'b0, 16'd0);
    load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) stepchk($sformatf("t5.l%0d", i), 1'b0, 1'b0, 16'(i));
    stepchk("t5.h0", 1'b1, 1'b1, 16'd0);
    rst = 1'b1;
    #1;
    chk("t5.async.clk_out", 32'(clk_out), 32'd0);
    chk("t5.async.tick", 32'(tick), 32'd0);
    step();
    step();
    rst = 1'b0;
    stepchk("t5.d_l0", 1'b0, 1'b0, 16'd0);
    stepchk("t5.d_h0", 1'b1, 1'b1, 16'd0);
    stepchk("t5.d_l1", 1'b0, 1'b0, 16'd0);
    stepchk("t5.d_h1", 1'b1, 1'b1, 16'd0);
    $display("t5 done: async reset sequence");

`ifdef CLOCK_GEN_TICK_CNT_EN
    // Test 6: tick counter accumulation and wrap
    do_reset();
    en = 1'b1;
    repeat (20) step();
    chk("t6.tick_cnt20", tick_cnt, 32'd10);
    dut.tick_cnt_reg = 32'hFFFF_FFFF;
    step();
    chk("t6.preload", tick_cnt, 32'hFFFF_FFFF);
    step();
    chk("t6.wrap.tick", 32'(tick), 32'd1);
    chk("t6.wrap", tick_cnt, 32'd0);
    $display("t6 done: tick_cnt sequence");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
